// File: rtl/srf_serial_regfile_pkg.sv
// Shared types and defaults for the serial-access register file.
package srf_serial_regfile_pkg;

  localparam int SRF_WIDTH_DEF = 8;
  localparam int SRF_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_IN  = 2'd1,
    ST_SHIFT_OUT = 2'd2,
    ST_DONE      = 2'd3
  } srf_state_e;

  function automatic logic srf_is_shifting(input srf_state_e st);
    return (st == ST_SHIFT_IN) || (st == ST_SHIFT_OUT);
  endfunction

endpackage

// File: rtl/srf_shift_reg.sv
// Loadable left-shift register shared by the serial write and read paths.
module srf_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             msb
);

  logic [WIDTH-1:0] shift_r;

  // load has priority over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {WIDTH{1'b0}};
    end else if (load) begin
      shift_r <= load_val;
    end else if (shift) begin
      shift_r <= {shift_r[WIDTH-2:0], sin};
    end else begin
      shift_r <= shift_r;
    end
  end

  assign q   = shift_r;
  assign msb = shift_r[WIDTH-1];

endmodule

// File: rtl/srf_serial_regfile.sv
// Serial register file: a rising srf_en starts an MSB-first write or read of one entry.
module srf_serial_regfile
  import srf_serial_regfile_pkg::*;
#(
  parameter int WIDTH  = SRF_WIDTH_DEF,
  parameter int DEPTH  = SRF_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              srf_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              data_in,
  output logic              data_out,
  output logic              done,
  output logic              busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  srf_state_e        state_r, state_nxt_s;
  logic              srf_en_d_r;
  logic [ADDR_W-1:0] addr_q_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              done_r, busy_r, rd_active_r;

  logic              start_s, last_s;
  logic              sr_load_s, sr_shift_s, mem_we_s;
  logic              done_nxt_s, busy_nxt_s, rd_active_nxt_s;
  logic [WIDTH-1:0]  sr_q_s, rd_word_s, mem_wdata_s;
  logic              sr_msb_s;

  assign start_s     = (state_r == ST_IDLE) && srf_en && !srf_en_d_r;
  assign last_s      = (cnt_r == CNT_W'(WIDTH - 1));
  assign rd_word_s   = mem_r[addr];
  assign mem_wdata_s = {sr_q_s[WIDTH-2:0], data_in};

  srf_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load_s),
    .shift    (sr_shift_s),
    .sin      (data_in),
    .load_val (rd_word_s),
    .q        (sr_q_s),
    .msb      (sr_msb_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; dropping srf_en mid-shift aborts straight to IDLE
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = we ? ST_SHIFT_IN : ST_SHIFT_OUT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT_IN, ST_SHIFT_OUT: begin
        if (!srf_en) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and next values of the registered outputs
  always_comb begin
    sr_load_s       = 1'b0;
    sr_shift_s      = 1'b0;
    mem_we_s        = 1'b0;
    busy_nxt_s      = srf_is_shifting(state_nxt_s);
    done_nxt_s      = (state_nxt_s == ST_DONE);
    rd_active_nxt_s = (state_nxt_s == ST_SHIFT_OUT);
    case (state_r)
      ST_IDLE:      sr_load_s = start_s && !we;
      ST_SHIFT_IN: begin
        sr_shift_s = srf_en;
        mem_we_s   = srf_en && last_s;
      end
      ST_SHIFT_OUT: sr_shift_s = srf_en;
      ST_DONE:      sr_load_s = 1'b0;
      default:      sr_load_s = 1'b0;
    endcase
  end

  // edge detect, transaction address, bit counter and output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srf_en_d_r  <= 1'b0;
      addr_q_r    <= {ADDR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      rd_active_r <= 1'b0;
    end else begin
      srf_en_d_r  <= srf_en;
      addr_q_r    <= start_s ? addr : addr_q_r;
      cnt_r       <= (srf_is_shifting(state_r) && srf_is_shifting(state_nxt_s)) ?
                     cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
      rd_active_r <= rd_active_nxt_s;
    end
  end

  // storage array, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_r[addr_q_r] <= mem_wdata_s;
    end else begin
      mem_r[addr_q_r] <= mem_r[addr_q_r];
    end
  end

  assign data_out = sr_msb_s & rd_active_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule
